// File: rtl/pixel_hit_tot_buffer.sv
// Per-pixel hit processor: synchronizes the hit level, measures ToT in BX cycles,
// timestamps the leading edge and queues completed hits in a small FWFT FIFO.
`timescale 1ns/1ps
module pixel_hit_tot_buffer #(
  parameter int unsigned TOT_W   = 4,
  parameter int unsigned TOT_MAX = 15,
  parameter int unsigned TS_W    = 8,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   HitIn,
  input  logic                   PowerDown,
  input  logic [TS_W-1:0]        BcId,
  output logic [TS_W+TOT_W-1:0]  HitDataOut,
  output logic                   HitValid,
  input  logic                   HitRead,
  output logic                   Overflow,
  input  logic                   ClearOverflow,
  output logic                   Busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = TS_W + TOT_W;

  typedef enum logic {IDLE, COUNT} state_e;

  state_e           state_q, state_d;
  logic             hs_meta_q, hs_q;
  logic [TOT_W-1:0] tot_q, tot_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [DW-1:0]    mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             commit, empty, full, pop, push, drop;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hs_meta_q <= 1'b0;
      hs_q      <= 1'b0;
      state_q   <= IDLE;
      tot_q     <= '0;
      ts_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      hs_meta_q <= HitIn;
      hs_q      <= hs_meta_q;
      state_q   <= state_d;
      tot_q     <= tot_d;
      ts_q      <= ts_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: HitDataOut is masked to zero whenever the FIFO is empty.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {ts_q, tot_q};
  end

  always_comb begin
    state_d = state_q;
    tot_d   = tot_q;
    ts_d    = ts_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!PowerDown && hs_q) begin
          state_d = COUNT;
          ts_d    = BcId;
          tot_d   = TOT_W'(1);
        end
      end
      COUNT: begin
        if (PowerDown) begin
          state_d = IDLE;
        end else if (hs_q) begin
          if (tot_q < TOT_W'(TOT_MAX)) tot_d = tot_q + 1'b1;
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a commit into a full FIFO still lands.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = HitRead && !empty;
    push     = commit && (!full || pop);
    drop     = commit && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    if (drop)               ovf_d = 1'b1;
    else if (ClearOverflow) ovf_d = 1'b0;
    else                    ovf_d = ovf_q;
  end

  always_comb begin
    HitValid   = !empty;
    HitDataOut = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    Overflow   = ovf_q;
    Busy       = (state_q == COUNT);
  end

endmodule

// File: tb/tb_pixel_hit_tot_buffer.sv
// Directed bench for pixel_hit_tot_buffer: queue-based hit model checked every cycle,
// plus literal expectations for the main scenarios.
`timescale 1ns/1ps
module tb_pixel_hit_tot_buffer;
  localparam int TOT_W = 4, TOT_MAX = 15, TS_W = 8, DEPTH = 4;

  logic Clk = 1'b0, Reset = 1'b1, HitIn = 1'b0, PowerDown = 1'b0;
  logic HitRead = 1'b0, ClearOverflow = 1'b0;
  logic [TS_W-1:0] BcId = '0;
  logic [TS_W+TOT_W-1:0] HitDataOut;
  logic HitValid, Overflow, Busy;

  pixel_hit_tot_buffer #(.TOT_W(TOT_W), .TOT_MAX(TOT_MAX), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .HitIn(HitIn), .PowerDown(PowerDown), .BcId(BcId),
    .HitDataOut(HitDataOut), .HitValid(HitValid), .HitRead(HitRead),
    .Overflow(Overflow), .ClearOverflow(ClearOverflow), .Busy(Busy)
  );

  always #10 Clk = ~Clk;

  int checks = 0, errors = 0;

  // Model: hit level seen two edges late, run length of the current hit, queue of entries.
  bit hist0, hist1;
  int run_len;
  logic [TS_W-1:0] run_ts;
  logic [TS_W+TOT_W-1:0] mq[$];
  bit m_ovf;
  bit bc_hold = 1'b0;

  function automatic void model_clear();
    hist0 = 0; hist1 = 0; run_len = 0; run_ts = '0; mq.delete(); m_ovf = 0;
  endfunction

  function automatic void model_step();
    bit hs, commit, drop, popq;
    logic [TS_W+TOT_W-1:0] ent;
    hs = hist1; hist1 = hist0; hist0 = HitIn;
    popq = HitRead && (mq.size() > 0);
    commit = 0; drop = 0; ent = '0;
    if (PowerDown) run_len = 0;
    else if (run_len == 0) begin
      if (hs) begin run_len = 1; run_ts = BcId; end
    end else if (hs) run_len++;
    else begin
      commit = 1;
      ent = {run_ts, 4'(run_len > TOT_MAX ? TOT_MAX : run_len)};
      run_len = 0;
    end
    if (popq) void'(mq.pop_front());
    if (commit) begin
      if (mq.size() < DEPTH) mq.push_back(ent);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (ClearOverflow) m_ovf = 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    logic [TS_W+TOT_W-1:0] exp_data;
    exp_data = '0;
    if (mq.size() > 0) exp_data = mq[0];
    check("model_valid", HitValid, (mq.size() > 0) ? 1 : 0);
    check("model_data", HitDataOut, exp_data);
    check("model_ovf", Overflow, m_ovf);
    check("model_busy", Busy, (run_len != 0) ? 1 : 0);
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      if (!Reset) model_step();
      @(negedge Clk);
      #1;
      if (!bc_hold) BcId++;
    end
  endtask

  // Commit edge falls two cycles after HitIn drops; clr/rd are applied exactly there.
  task automatic hit(input int len, input bit clr_c, input bit rd_c);
    HitIn = 1; cyc(len);
    HitIn = 0; cyc(2);
    ClearOverflow = clr_c; HitRead = rd_c; cyc(1);
    ClearOverflow = 0; HitRead = 0; cyc(3);
  endtask

  task automatic drain(output int n, output logic [TS_W+TOT_W-1:0] last);
    n = 0; last = '0;
    while (HitValid && n < 16) begin
      last = HitDataOut;
      HitRead = 1; cyc(1); n++;
    end
    HitRead = 0;
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, busy_cnt;
    logic [TS_W+TOT_W-1:0] last;
    model_clear();
    cyc(3);
    check("rst_valid", HitValid, 0);
    check("rst_data", HitDataOut, 0);
    check("rst_ovf", Overflow, 0);
    check("rst_busy", Busy, 0);
    Reset = 0;
    cyc(3);

    // Basic hit
    bc_hold = 1; BcId = 8'h10; busy_cnt = 0;
    HitIn = 1;
    repeat (5) begin cyc(1); busy_cnt += Busy; end
    HitIn = 0;
    repeat (4) begin cyc(1); busy_cnt += Busy; end
    check("basic_busy_cycles", busy_cnt, 5);
    check("basic_valid", HitValid, 1);
    check("basic_data", HitDataOut, 12'h105);
    bc_hold = 0;
    HitRead = 1; cyc(1); HitRead = 0;
    check("basic_pop_valid", HitValid, 0);
    check("basic_pop_data", HitDataOut, 0);

    // Saturation
    HitIn = 1; cyc(30); HitIn = 0; cyc(1);
    check("sat_no_early_commit", HitValid, 0);
    cyc(3);
    check("sat_valid", HitValid, 1);
    check("sat_tot", HitDataOut[3:0], 15);
    drain(n, last);
    check("sat_count", n, 1);

    // Overflow
    repeat (5) hit(2, 0, 0);
    check("ovf_set", Overflow, 1);
    check("ovf_head_tot", HitDataOut[3:0], 2);
    ClearOverflow = 1; cyc(1); ClearOverflow = 0;
    check("ovf_clear", Overflow, 0);
    hit(2, 1, 0);
    check("ovf_set_wins", Overflow, 1);

    // Full with simultaneous pop
    ClearOverflow = 1; cyc(1); ClearOverflow = 0;
    check("fullpop_pre_ovf", Overflow, 0);
    hit(3, 0, 1);
    check("fullpop_ovf", Overflow, 0);
    drain(n, last);
    check("fullpop_occupancy", n, 4);
    check("fullpop_last_tot", last[3:0], 3);

    // PowerDown
    HitIn = 1; cyc(3);
    check("pd_busy_before", Busy, 1);
    PowerDown = 1; cyc(1);
    check("pd_busy_after", Busy, 0);
    cyc(2); HitIn = 0; cyc(4);
    check("pd_no_entry", HitValid, 0);
    HitIn = 1; cyc(4); HitIn = 0; cyc(4);
    check("pd_ignored_hit", HitValid, 0);
    check("pd_ignored_busy", Busy, 0);
    PowerDown = 0; cyc(2);
    hit(2, 0, 0);
    PowerDown = 1; cyc(1);
    check("pd_drain_valid", HitValid, 1);
    HitRead = 1; cyc(1); HitRead = 0;
    check("pd_drain_empty", HitValid, 0);
    PowerDown = 0; cyc(2);

    // Reset mid-operation
    hit(2, 0, 0);
    hit(3, 0, 0);
    HitIn = 1; cyc(4);
    check("rstmid_busy", Busy, 1);
    check("rstmid_valid", HitValid, 1);
    #3; Reset = 1; model_clear(); #1;
    check("rstmid_async_valid", HitValid, 0);
    check("rstmid_async_data", HitDataOut, 0);
    check("rstmid_async_busy", Busy, 0);
    check("rstmid_async_ovf", Overflow, 0);
    cyc(2);
    #4; Reset = 0;
    cyc(4);
    HitIn = 0; cyc(6);
    check("rstmid_valid_after", HitValid, 1);
    check("rstmid_partial_tot", HitDataOut[3:0], 4);
    drain(n, last);
    check("rstmid_count", n, 1);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_hit_tot_buffer.md
Name: pixel_hit_tot_buffer

Overview:
- Per-pixel digital hit processor directly downstream of the pixel front-end control stage.
- Consumes the gated pixel hit (HitOut) and the pixel power-down flag (PowerDownToRegion).
- Measures time-over-threshold (ToT) in bunch-crossing clock cycles and timestamps the leading edge with the current BX counter.
- Stores completed hits in a small first-word-fall-through (FWFT) FIFO, which the region readout drains through a valid/read handshake.

Parameters:
- TOT_W, 4, ToT field width in bits.
- TOT_MAX, 15, ToT saturation value; must be <= 2^TOT_W-1.
- TS_W, 8, timestamp (BX ID) width in bits.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- Clk  input  1  40 MHz BX clock.
- Reset  input  1  asynchronous, active-high reset.
- HitIn  input  1  pixel hit level from the front-end control stage; asynchronous to Clk.
- PowerDown  input  1  pixel disabled (hit_en=0); synchronous to Clk.
- BcId  input  TS_W  free-running BX counter.
- HitDataOut  output  TS_W+TOT_W  head FIFO entry {timestamp, tot}; all zeros when empty.
- HitValid  output  1  FIFO not empty.
- HitRead  input  1  pop request from readout.
- Overflow  output  1  sticky flag: a hit was dropped.
- ClearOverflow  input  1  synchronous clear of Overflow.
- Busy  output  1  a hit measurement is in progress.

Behaviour:
- Reset is asynchronous and active-high, on Clk.
- Reset values:
  - synchronizer flops 0, FSM IDLE, tot 0, captured timestamp 0;
  - FIFO empty (read and write pointers 0);
  - HitValid 0, HitDataOut 0, Overflow 0, Busy 0.
- Synchronizer: two-flop synchronizer on HitIn produces hs. The synchronizer adds 2 cycles of latency and is the only path from HitIn.
- FSM IDLE:
  - if PowerDown=0 and hs=1, go to COUNT;
  - latch ts=BcId sampled in that same cycle;
  - set tot=1.
- FSM COUNT:
  - hs=1: tot=min(tot+1, TOT_MAX); saturate and keep waiting for the trailing edge.
  - hs=0: commit {ts, tot} to the FIFO and return to IDLE in the same cycle. A new leading edge is accepted from the next cycle.
- ToT definition: number of Clk cycles hs was 1, saturating at TOT_MAX. The minimum recorded ToT is 1.
- PowerDown=1:
  - the FSM is forced to IDLE and any in-progress hit is discarded (no commit, no Overflow);
  - new edges are ignored;
  - FIFO contents and readout keep working.
- Busy=1 exactly when the FSM is in COUNT.
- FIFO:
  - FWFT: HitValid=~empty, and HitDataOut=head entry combinationally from the registers.
  - Pop happens when HitRead & HitValid at a rising Clk edge.
  - HitRead while empty is ignored.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally; full and empty are decoded from the MSB and the equality of the remaining bits.
- Commit while full with no simultaneous pop: the entry is dropped and Overflow is set.
- Commit while full with a simultaneous pop: the entry is accepted, and the occupancy stays DEPTH.
- Commit and pop in the same cycle when not full: both happen, and occupancy is unchanged.
- Overflow: sticky. ClearOverflow=1 clears it. If a drop and ClearOverflow occur in the same cycle, Overflow stays 1 (set wins).
- BcId wrap: the timestamp is taken as a raw value; no wrap correction is applied in this block.
- Reset mid-hit:
  - the in-progress measurement and all FIFO contents are lost;
  - if HitIn is still high after reset release, a new hit starts when hs first reads 1, i.e. 2–3 cycles after release, with a partial ToT.

Test Plan:
- Basic hit: BcId=0x10 at the leading edge seen on hs, HitIn high for 5 cycles → one entry {0x10, 5}; HitValid=1; Busy high for 5 cycles; a HitRead pulse makes HitValid 0 and HitDataOut 0.
- Saturation: HitIn high for 30 cycles → tot=15 (TOT_MAX); a single entry is committed only after the falling edge.
- Overflow: 5 hits of ToT 2 with no reads (DEPTH=4) → 4 entries retained in order; 5th dropped; Overflow=1. ClearOverflow → Overflow=0. A commit on the same cycle as ClearOverflow with FIFO full → Overflow stays 1.
- Full with simultaneous pop: FIFO full, commit and HitRead in the same cycle → oldest entry removed, new entry appended, occupancy 4, Overflow=0.
- PowerDown: assert PowerDown in cycle 3 of a 6-cycle hit → no entry, Busy drops next cycle. A hit while PowerDown=1 → no entry. Pre-existing entries still drain normally.
- Reset mid-operation: 2 entries stored plus a hit in progress, then assert Reset asynchronously → all outputs 0 immediately. HitIn held high across release → one new entry with partial ToT after HitIn falls.
